sort_datapath: RTL and testbench

- Datapath for the in-place bubble-sort engine, directly downstream of the sort controller.
- Consumes the controller's strobes: Li, Lj, Ei, Ej, EA, EB, WR, Csel, Bout.
- Returns the status flags zi, zj and AgtB to the controller.
- Holds the N-word array, the outer index i, the inner index j, and operand registers A and B. A host port loads the array before a sort and reads it back afterwards.

---
 rtl/sort_pkg.sv | 25 ++
 rtl/sort_datapath_if.sv | 42 ++++
 rtl/sort_mem.sv | 59 +++++
 rtl/sort_datapath.sv | 80 ++++++++
 tb/tb_sort_datapath.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the bubble-sort datapath slice.
//   DEF_N / DEF_W : default array depth and word width
//   addr_width()  : index/address width for an N-word array (at least 1 bit)
//   addr_sel_e    : Csel encoding (which index drives the array address)
//   wsrc_sel_e    : Bout encoding (which operand register is written back)
package sort_pkg;

  localparam int unsigned DEF_N = 8;
  localparam int unsigned DEF_W = 8;

  function automatic int unsigned addr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_J = 1'b1
  } addr_sel_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } wsrc_sel_e;

endpackage

// File: rtl/sort_datapath_if.sv
// Controller/host bus of the sort datapath.
//   master : sort controller + host (drives strobes and host port, sees flags)
//   slave  : sort_datapath (sees strobes and host port, drives flags and ext_dout)
// Strobes : Li Ei Lj Ej EA EB WR Csel Bout
// Flags   : zi zj AgtB
// Host    : ext_we ext_addr ext_din ext_dout
interface sort_datapath_if #(
  parameter int unsigned N = sort_pkg::DEF_N,
  parameter int unsigned W = sort_pkg::DEF_W
);
  localparam int unsigned AW = sort_pkg::addr_width(N);

  logic          Li;
  logic          Ei;
  logic          Lj;
  logic          Ej;
  logic          EA;
  logic          EB;
  logic          WR;
  logic          Csel;
  logic          Bout;
  logic          zi;
  logic          zj;
  logic          AgtB;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [W-1:0]  ext_din;
  logic [W-1:0]  ext_dout;

  modport master (
    output Li, Ei, Lj, Ej, EA, EB, WR, Csel, Bout,
    output ext_we, ext_addr, ext_din,
    input  zi, zj, AgtB, ext_dout
  );

  modport slave (
    input  Li, Ei, Lj, Ej, EA, EB, WR, Csel, Bout,
    input  ext_we, ext_addr, ext_din,
    output zi, zj, AgtB, ext_dout
  );

endinterface

// File: rtl/sort_mem.sv
// N x W register array for the sort datapath.
//   clk, rst                : clock, synchronous active-low reset (gates writes only)
//   dp_addr / dp_rdata      : datapath async read port
//   dp_we / dp_wdata        : datapath write (priority over host)
//   host_addr / host_rdata  : host async read port (0 for out-of-range address)
//   host_we / host_wdata    : host write (dropped when dp_we is high)
// Contents are never cleared by reset.
module sort_mem
  import sort_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned W  = DEF_W,
  parameter int unsigned AW = addr_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] dp_addr,
  output logic [W-1:0]  dp_rdata,
  input  logic          dp_we,
  input  logic [W-1:0]  dp_wdata,
  input  logic [AW-1:0] host_addr,
  output logic [W-1:0]  host_rdata,
  input  logic          host_we,
  input  logic [W-1:0]  host_wdata
);

  logic [W-1:0] mem_q [N];
  logic [W-1:0] mem_d [N];
  logic         dp_ok;
  logic         host_ok;

  // Range guards only exist when N does not fill the address space.
  if (N == (32'd1 << AW)) begin : g_full
    assign dp_ok   = 1'b1;
    assign host_ok = 1'b1;
  end else begin : g_partial
    assign dp_ok   = (32'(dp_addr) < N);
    assign host_ok = (32'(host_addr) < N);
  end

  assign dp_rdata   = dp_ok   ? mem_q[dp_addr]   : '0;
  assign host_rdata = host_ok ? mem_q[host_addr] : '0;

  always_comb begin
    mem_d = mem_q;
    if (rst) begin
      if (dp_we) begin
        if (dp_ok) mem_d[dp_addr] = dp_wdata;
      end else if (host_we && host_ok) begin
        mem_d[host_addr] = host_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sort_datapath.sv
// Datapath of the in-place bubble-sort engine.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-low reset (clears i, j, A, B; array kept)
//   bus  : sort_datapath_if.slave -- controller strobes, status flags
//          (zi = i==N-2, zj = j==N-1, AgtB = A>B unsigned) and host port
// Holds indices i/j, operand registers A/B and the array (sort_mem).
module sort_datapath
  import sort_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W
) (
  input  logic clk,
  input  logic rst,
  sort_datapath_if.slave bus
);

  localparam int unsigned   AW     = addr_width(N);
  localparam logic [AW-1:0] I_LAST = AW'(N - 2);
  localparam logic [AW-1:0] J_LAST = AW'(N - 1);

  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [AW-1:0] addr;
  logic [W-1:0]  rdata;
  logic [W-1:0]  wdata;

  assign addr  = (bus.Csel == SEL_J) ? j_q : i_q;
  assign wdata = (bus.Bout == SRC_B) ? b_q : a_q;

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    a_d = a_q;
    b_d = b_q;
    if (bus.Ei) i_d = bus.Li ? '0 : i_q + AW'(1);
    // j's load deliberately uses the pre-edge i.
    if (bus.Ej) j_d = bus.Lj ? i_q + AW'(1) : j_q + AW'(1);
    if (bus.EA) a_d = rdata;
    if (bus.EB) b_d = rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      i_q <= '0;
      j_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign bus.zi   = (i_q == I_LAST);
  assign bus.zj   = (j_q == J_LAST);
  assign bus.AgtB = (a_q > b_q);

  sort_mem #(
    .N  (N),
    .W  (W),
    .AW (AW)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .dp_addr    (addr),
    .dp_rdata   (rdata),
    .dp_we      (bus.WR),
    .dp_wdata   (wdata),
    .host_addr  (bus.ext_addr),
    .host_rdata (bus.ext_dout),
    .host_we    (bus.ext_we),
    .host_wdata (bus.ext_din)
  );

endmodule

// File: tb/tb_sort_datapath.sv
module tb_sort_datapath;
  import sort_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned M  = 1 << AW;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic rst2 = 1'b0;
  always #5 clk = ~clk;

  sort_datapath_if #(.N(N), .W(W)) bus ();
  sort_datapath #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  sort_datapath_if #(.N(2), .W(W)) bus2 ();
  sort_datapath #(.N(2), .W(W)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  int m_i, m_j, m_a, m_b;
  int m_mem [N];
  bit known [N];

  int init_vals [N] = '{5, 3, 7, 1, 8, 2, 6, 4};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    bus.Li = 0; bus.Ei = 0; bus.Lj = 0; bus.Ej = 0;
    bus.EA = 0; bus.EB = 0; bus.WR = 0; bus.Csel = 0; bus.Bout = 0;
    bus.ext_we = 0; bus.ext_din = '0;
  endtask

  task automatic clr2();
    bus2.Li = 0; bus2.Ei = 0; bus2.Lj = 0; bus2.Ej = 0;
    bus2.EA = 0; bus2.EB = 0; bus2.WR = 0; bus2.Csel = 0; bus2.Bout = 0;
    bus2.ext_we = 0; bus2.ext_addr = '0; bus2.ext_din = '0;
  endtask

  // Applies the spec's per-edge rules to the model using current inputs.
  task automatic model_edge();
    int addr, rd, ni, nj;
    if (!rst) begin
      m_i = 0; m_j = 0; m_a = 0; m_b = 0;
      return;
    end
    addr = bus.Csel ? m_j : m_i;
    rd   = m_mem[addr];
    ni   = bus.Ei ? (bus.Li ? 0 : (m_i + 1) % M) : m_i;
    nj   = bus.Ej ? (bus.Lj ? (m_i + 1) % M : (m_j + 1) % M) : m_j;
    if (bus.WR) begin
      m_mem[addr] = bus.Bout ? m_b : m_a;
      known[addr] = 1;
    end else if (bus.ext_we) begin
      m_mem[bus.ext_addr] = int'(bus.ext_din);
      known[bus.ext_addr] = 1;
    end
    if (bus.EA) m_a = rd;
    if (bus.EB) m_b = rd;
    m_i = ni;
    m_j = nj;
  endtask

  task automatic check_all();
    check("zi",   32'(bus.zi),   32'(m_i == int'(N) - 2));
    check("zj",   32'(bus.zj),   32'(m_j == int'(N) - 1));
    check("AgtB", 32'(bus.AgtB), 32'(m_a > m_b));
    check("i",    32'(dut.i_q),  32'(m_i));
    check("j",    32'(dut.j_q),  32'(m_j));
    check("A",    32'(dut.a_q),  32'(m_a));
    check("B",    32'(dut.b_q),  32'(m_b));
    if (known[bus.ext_addr]) check("ext_dout", 32'(bus.ext_dout), 32'(m_mem[bus.ext_addr]));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_all();
  endtask

  task automatic tick2();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input int d);
    clr();
    bus.ext_we = 1; bus.ext_addr = AW'(a); bus.ext_din = W'(d);
    step();
    clr();
  endtask

  task automatic readback(input string tag, input int exp [N]);
    for (int k = 0; k < int'(N); k++) begin
      bus.ext_addr = AW'(k);
      #1;
      check(tag, 32'(bus.ext_dout), 32'(exp[k]));
    end
  endtask

  // Bench-side controller: exchange sort driven purely from the flags.
  task automatic run_sort(output int wr_cnt, output bit done);
    int limit;
    limit  = cyc + 2000;
    wr_cnt = 0;
    done   = 0;
    clr(); bus.Li = 1; bus.Ei = 1; step(); clr();
    while (!done && cyc < limit) begin
      bus.Lj = 1; bus.Ej = 1; step(); clr();
      while (cyc < limit) begin
        bus.EA = 1; bus.Csel = 0; step(); clr();
        bus.EB = 1; bus.Csel = 1; step(); clr();
        if (bus.AgtB) begin
          bus.WR = 1; bus.Csel = 0; bus.Bout = 1; step(); clr();
          bus.WR = 1; bus.Csel = 1; bus.Bout = 0; step(); clr();
          wr_cnt += 2;
        end
        if (bus.zj) break;
        bus.Ej = 1; step(); clr();
      end
      if (bus.zi) done = 1;
      else begin
        bus.Ei = 1; step(); clr();
      end
    end
  endtask

  initial begin
    int sorted [N] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int wr_cnt;
    bit done;

    for (int k = 0; k < int'(N); k++) known[k] = 0;
    clr(); clr2();
    bus.ext_addr = '0;
    rst = 0;
    step(); step();
    rst = 1;

    // Host load and readback
    for (int k = 0; k < int'(N); k++) host_write(k, init_vals[k]);
    readback("host_rd", init_vals);

    // Make registers nonzero before the reset test
    bus.Li = 1; bus.Ei = 1; step(); clr();
    bus.Lj = 1; bus.Ej = 1; step(); clr();
    bus.EA = 1; bus.Csel = 0; step(); clr();
    bus.EB = 1; bus.Csel = 1; step(); clr();
    check("pre_rst_A", 32'(dut.a_q), 32'd5);

    // Reset with every strobe high, including writes
    bus.Li = 1; bus.Ei = 1; bus.Lj = 1; bus.Ej = 1; bus.EA = 1; bus.EB = 1;
    bus.WR = 1; bus.Csel = 1; bus.Bout = 1;
    bus.ext_we = 1; bus.ext_addr = AW'(2); bus.ext_din = 8'hFF;
    rst = 0;
    step(); step();
    check("rst_zi",   32'(bus.zi),   32'd0);
    check("rst_zj",   32'(bus.zj),   32'd0);
    check("rst_AgtB", 32'(bus.AgtB), 32'd0);
    check("rst_i",    32'(dut.i_q),  32'd0);
    check("rst_j",    32'(dut.j_q),  32'd0);
    check("rst_A",    32'(dut.a_q),  32'd0);
    check("rst_B",    32'(dut.b_q),  32'd0);
    rst = 1;
    clr();
    readback("rst_mem", init_vals);

    // Index control
    bus.Li = 1; bus.Ei = 1; step(); clr();
    check("i_load", 32'(dut.i_q), 32'd0);
    bus.Lj = 1; bus.Ej = 1; step(); clr();
    check("j_load", 32'(dut.j_q), 32'd1);
    for (int k = 0; k < 5; k++) begin bus.Ej = 1; step(); clr(); end
    check("j_6", 32'(dut.j_q), 32'd6);
    check("zj_6", 32'(bus.zj), 32'd0);
    bus.Ej = 1; step(); clr();
    check("j_7", 32'(dut.j_q), 32'd7);
    check("zj_7", 32'(bus.zj), 32'd1);
    for (int k = 0; k < 6; k++) begin bus.Ei = 1; step(); clr(); end
    check("i_6", 32'(dut.i_q), 32'd6);
    check("zi_6", 32'(bus.zi), 32'd1);
    bus.Li = 1; step(); clr();
    check("li_no_ei", 32'(dut.i_q), 32'd6);

    // Fetch / compare
    bus.Li = 1; bus.Ei = 1; step(); clr();
    bus.Lj = 1; bus.Ej = 1; step(); clr();
    bus.EA = 1; bus.Csel = 0; step(); clr();
    bus.EB = 1; bus.Csel = 1; step(); clr();
    check("fetch_A", 32'(dut.a_q), 32'd5);
    check("fetch_B", 32'(dut.b_q), 32'd3);
    check("gt_5_3", 32'(bus.AgtB), 32'd1);
    host_write(1, 9);
    bus.EB = 1; bus.Csel = 1; step(); clr();
    check("gt_5_9", 32'(bus.AgtB), 32'd0);
    host_write(1, 5);
    bus.EB = 1; bus.Csel = 1; step(); clr();
    check("gt_5_5", 32'(bus.AgtB), 32'd0);
    host_write(1, 3);
    bus.EB = 1; bus.Csel = 1; step(); clr();

    // Swap
    bus.WR = 1; bus.Csel = 0; bus.Bout = 1; step(); clr();
    bus.WR = 1; bus.Csel = 1; bus.Bout = 0; step(); clr();
    bus.ext_addr = AW'(0); #1; check("swap_m0", 32'(bus.ext_dout), 32'd3);
    bus.ext_addr = AW'(1); #1; check("swap_m1", 32'(bus.ext_dout), 32'd5);
    check("swap_A", 32'(dut.a_q), 32'd5);
    check("swap_B", 32'(dut.b_q), 32'd3);

    // WR wins over host write
    bus.WR = 1; bus.Csel = 0; bus.Bout = 0;
    bus.ext_we = 1; bus.ext_addr = AW'(4); bus.ext_din = 8'hEE;
    step(); clr();
    bus.ext_addr = AW'(4); #1; check("wr_prio", 32'(bus.ext_dout), 32'd8);
    bus.ext_addr = AW'(0); #1; check("wr_prio_dp", 32'(bus.ext_dout), 32'd5);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 31) != 0);
      bus.Li = 1'($urandom); bus.Ei = 1'($urandom);
      bus.Lj = 1'($urandom); bus.Ej = 1'($urandom);
      bus.EA = 1'($urandom); bus.EB = 1'($urandom);
      bus.WR = ($urandom_range(0, 3) == 0);
      bus.Csel = 1'($urandom); bus.Bout = 1'($urandom);
      bus.ext_we = 1'($urandom);
      bus.ext_addr = AW'($urandom_range(0, N - 1));
      bus.ext_din = W'($urandom);
      step();
    end
    rst = 1;
    clr();

    // Closed loop sort of the host-load array
    for (int k = 0; k < int'(N); k++) host_write(k, init_vals[k]);
    run_sort(wr_cnt, done);
    check("sort_done", 32'(done), 32'd1);
    readback("sorted", sorted);
    run_sort(wr_cnt, done);
    check("resort_done", 32'(done), 32'd1);
    check("resort_wr", 32'(wr_cnt), 32'd0);
    readback("resorted", sorted);

    // N=2 instance
    rst2 = 0; tick2();
    check("n2_rst_zi",   32'(bus2.zi),   32'd1);
    check("n2_rst_zj",   32'(bus2.zj),   32'd0);
    check("n2_rst_AgtB", 32'(bus2.AgtB), 32'd0);
    rst2 = 1;
    bus2.ext_we = 1; bus2.ext_addr = 1'b0; bus2.ext_din = 8'd9; tick2();
    bus2.ext_addr = 1'b1; bus2.ext_din = 8'd4; tick2(); clr2();
    bus2.Li = 1; bus2.Ei = 1; tick2(); clr2();
    bus2.Lj = 1; bus2.Ej = 1; tick2(); clr2();
    check("n2_zj", 32'(bus2.zj), 32'd1);
    bus2.EA = 1; bus2.Csel = 0; tick2(); clr2();
    bus2.EB = 1; bus2.Csel = 1; tick2(); clr2();
    check("n2_AgtB", 32'(bus2.AgtB), 32'd1);
    bus2.WR = 1; bus2.Csel = 0; bus2.Bout = 1; tick2(); clr2();
    bus2.WR = 1; bus2.Csel = 1; bus2.Bout = 0; tick2(); clr2();
    bus2.ext_addr = 1'b0; #1; check("n2_m0", 32'(bus2.ext_dout), 32'd4);
    bus2.ext_addr = 1'b1; #1; check("n2_m1", 32'(bus2.ext_dout), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
